// File: rtl/pwm_cmd_sched.sv
// Rpm command to PWM duty scheduler: converts rpm to a duty percent and applies it at PWM period boundaries.
// Build option: define PWM_CMD_SLEW_LIMIT_EN to ramp the duty in SLEW_STEP increments instead of one jump.
module pwm_cmd_sched #(
  parameter int PERIOD_W   = 16,
  parameter int RPM_MIN    = 500,
  parameter int DUTY_MAX   = 90,
  parameter int DUTY_SCALE = 655,
  parameter int SLEW_STEP  = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] cmd_rpm,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [15:0] mot_rpm,
  output logic        set,
  output logic        at_target
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [7:0]          target_q, target_d;
  logic [7:0]          applied_q, applied_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [15:0]         mot_rpm_q, mot_rpm_d;
  logic                set_q, set_d;

  logic        accept;
  logic        terminal;
  logic [15:0] rpm_excess;
  logic [15:0] pct_raw;
  logic [7:0]  cmd_pct;
  logic [7:0]  step_pct;
  logic [31:0] duty_prod;
  logic [15:0] duty_sat;

  assign cmd_ready = (state_q != ISSUE);
  assign accept    = cmd_valid && cmd_ready;
  assign terminal  = &cnt_q;
  assign at_target = (applied_q == target_q);
  assign mot_rpm   = mot_rpm_q;
  assign set       = set_q;

  always_comb begin
    rpm_excess = cmd_rpm - 16'(RPM_MIN);
    pct_raw    = rpm_excess >> 6;
    if (cmd_rpm <= 16'(RPM_MIN)) begin
      cmd_pct = 8'd0;
    end else if (pct_raw > 16'(DUTY_MAX)) begin
      cmd_pct = 8'(DUTY_MAX);
    end else begin
      cmd_pct = pct_raw[7:0];
    end
  end

`ifdef PWM_CMD_SLEW_LIMIT_EN
  logic [7:0] diff;
  logic [7:0] mag;

  // Step by at most SLEW_STEP; clamping to diff prevents any overshoot.
  always_comb begin
    if (target_q >= applied_q) begin
      diff = target_q - applied_q;
    end else begin
      diff = applied_q - target_q;
    end
    mag = (diff > 8'(SLEW_STEP)) ? 8'(SLEW_STEP) : diff;
    if (target_q >= applied_q) begin
      step_pct = applied_q + mag;
    end else begin
      step_pct = applied_q - mag;
    end
  end
`else
  assign step_pct = target_q;

  // SLEW_STEP has no effect without slew limiting; this block elaborates to nothing.
  if (SLEW_STEP < 0) begin : g_slew_step_unused
  end
`endif

  assign duty_prod = 32'(step_pct) * 32'(DUTY_SCALE);
  assign duty_sat  = (duty_prod > 32'h0000_FFFF) ? 16'hFFFF : duty_prod[15:0];

  always_comb begin
    state_d   = state_q;
    applied_d = applied_q;
    mot_rpm_d = mot_rpm_q;
    set_d     = 1'b0;
    target_d  = accept ? cmd_pct : target_q;
    cnt_d     = set_q ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (applied_q != target_q) state_d = WAIT;
      end
      WAIT: begin
        // A retarget back to the applied duty cancels the pending update.
        if (applied_q == target_q) begin
          state_d = IDLE;
        end else if (terminal) begin
          applied_d = step_pct;
          mot_rpm_d = duty_sat;
          set_d     = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = (applied_q == target_q) ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      target_q  <= 8'd0;
      applied_q <= 8'd0;
      cnt_q     <= '0;
      mot_rpm_q <= 16'd0;
      set_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      applied_q <= applied_d;
      cnt_q     <= cnt_d;
      mot_rpm_q <= mot_rpm_d;
      set_q     <= set_d;
    end
  end

endmodule

// File: tb/tb_pwm_cmd_sched.sv
// Directed bench for pwm_cmd_sched with a scoreboard of expected duty percents, one per set pulse.
module tb_pwm_cmd_sched;

  logic        clk;
  logic        resetn;
  logic [15:0] cmd_rpm;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] mot_rpm;
  logic        set;
  logic        at_target;

  int checks = 0;
  int errors = 0;
  int set_count = 0;
  int n_pushed = 0;
  int base;
  logic [7:0] model_cur = 8'd0;
  logic [7:0] exp_q[$];

  pwm_cmd_sched #(.PERIOD_W(4)) dut (
    .clk(clk), .resetn(resetn), .cmd_rpm(cmd_rpm), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .mot_rpm(mot_rpm), .set(set), .at_target(at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pct_of(input int rpm);
    int p;
    if (rpm <= 500) return 8'd0;
    p = (rpm - 500) / 64;
    if (p > 90) p = 90;
    return 8'(p);
  endfunction

  function automatic int rpm_of(input logic [7:0] pct);
    int v;
    v = int'(pct) * 655;
    return (v > 65535) ? 65535 : v;
  endfunction

  // Expected sequence of applied percents from the current applied value to tgt.
  task automatic push_seq(input logic [7:0] tgt);
    int cur;
    int t;
    exp_q.delete();
    n_pushed = 0;
    cur = int'(model_cur);
    t = int'(tgt);
    while (cur != t) begin
`ifdef PWM_CMD_SLEW_LIMIT_EN
      if (t > cur) cur = (t - cur > 10) ? cur + 10 : t;
      else         cur = (cur - t > 10) ? cur - 10 : t;
`else
      cur = t;
`endif
      exp_q.push_back(8'(cur));
      n_pushed++;
    end
  endtask

  always @(negedge clk) begin
    if (resetn && set) begin
      set_count++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_set observed mot_rpm=%0d expected no set", mot_rpm);
      end
      if (exp_q.size() > 0) begin
        model_cur = exp_q.pop_front();
        chk("set_mot_rpm", int'(mot_rpm), rpm_of(model_cur));
      end
    end
  end

  task automatic drive_cmd(input int rpm);
    cmd_rpm = 16'(rpm);
    cmd_valid = 1'b1;
    for (int i = 0; i < 8 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready_before_accept", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    push_seq(pct_of(rpm));
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && at_target) break;
    end
    chk({tag, "_timeout"}, int'(i < 300), 1);
  endtask

  task automatic wait_sets(input int target_count, input string tag);
    int i;
    for (i = 0; i < 200 && set_count < target_count; i++) @(negedge clk);
    chk({tag, "_timeout"}, int'(set_count >= target_count), 1);
  endtask

  initial begin
    resetn = 1'b0;
    cmd_rpm = 16'd0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mot_rpm", int'(mot_rpm), 0);
    chk("rst_set", int'(set), 0);
    chk("rst_at_target", int'(at_target), 1);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    resetn = 1'b1;
    @(negedge clk);

    // Minimum rpm maps to 0 %: nothing to issue.
    base = set_count;
    drive_cmd(500);
    repeat (40) @(negedge clk);
    chk("min_rpm_sets", set_count - base, 0);
    chk("min_rpm_mot_rpm", int'(mot_rpm), 0);
    chk("min_rpm_at_target", int'(at_target), 1);

    // 3700 rpm -> 50 %.
    base = set_count;
    drive_cmd(3700);
    chk("ramp50_not_at_target", int'(at_target), 0);
    wait_done("ramp50");
    chk("ramp50_sets", set_count - base, n_pushed);
    chk("ramp50_mot_rpm", int'(mot_rpm), 32750);
    chk("ramp50_at_target", int'(at_target), 1);

    // 6580 rpm saturates at 90 %.
    base = set_count;
    drive_cmd(6580);
    wait_done("sat90");
    chk("sat90_sets", set_count - base, n_pushed);
    chk("sat90_mot_rpm", int'(mot_rpm), 58950);

    // cmd_valid held high across an ISSUE cycle.
    base = set_count;
    cmd_rpm = 16'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    push_seq(8'd0);
    for (int i = 0; i < 60 && !set; i++) @(negedge clk);
    chk("hold_set_seen", int'(set), 1);
    chk("hold_ready_in_issue", int'(cmd_ready), 0);
    @(negedge clk);
    chk("hold_ready_after_issue", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("hold");
    chk("hold_sets", set_count - base, n_pushed);
    chk("hold_mot_rpm", int'(mot_rpm), 0);

    // Retarget to the currently applied duty while waiting: no further set.
    base = set_count;
    drive_cmd(3700);
`ifdef PWM_CMD_SLEW_LIMIT_EN
    wait_sets(base + 3, "midramp");
    chk("midramp_applied", int'(model_cur), 30);
    drive_cmd(2420);
    repeat (40) @(negedge clk);
    chk("midramp_sets", set_count - base, 3);
    chk("midramp_mot_rpm", int'(mot_rpm), 19650);
`else
    drive_cmd(500);
    repeat (40) @(negedge clk);
    chk("retarget_sets", set_count - base, 0);
    chk("retarget_mot_rpm", int'(mot_rpm), 0);
`endif
    chk("retarget_at_target", int'(at_target), 1);

    // Reach 20 %, start another change, then reset while waiting.
    base = set_count;
    drive_cmd(1780);
    wait_sets(base + 1, "to20");
    chk("to20_mot_rpm", int'(mot_rpm), 13100);
    drive_cmd(3700);
    @(negedge clk);
    chk("wait20_at_target", int'(at_target), 0);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_mot_rpm", int'(mot_rpm), 0);
    chk("midrst_set", int'(set), 0);
    chk("midrst_at_target", int'(at_target), 1);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    exp_q.delete();
    model_cur = 8'd0;
    base = set_count;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    chk("postrst_sets", set_count - base, 0);
    chk("postrst_mot_rpm", int'(mot_rpm), 0);
    chk("postrst_at_target", int'(at_target), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
